program_loader: RTL

Upstream feeder for the processor core. Receives a program as a byte stream over a valid/ready handshake and packs every three bytes into one 23-bit instruction word. Drives the core's program-load port (`program_in`, `write`, `address`) for sequential program-memory writes from address 0. After the last word, issues a one-cycle `start` pulse to the core's controller and PC.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/byte_packer.sv | 45 ++++
 rtl/program_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the program loader: loader FSM state encoding,
// instruction/address geometry and the number of stream bytes per word.
// No ports (package).
// ---------------------------------------------------------------------------
package loader_pkg;

  localparam int INSTR_W        = 23;
  localparam int ADDR_W         = 6;
  localparam int MAX_WORDS      = 64;
  localparam int BYTES_PER_WORD = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN,
    S_B0,
    S_B1,
    S_B2,
    S_WR,
    S_CHK,
    S_STRT,
    S_ERR
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Collects the three big-endian bytes of one instruction word. The first two
// bytes live in a shift register; the packed word is presented combinationally
// together with the third byte so the owner can capture it on that transfer.
//
// Ports:
//   clk       in  1        rising-edge clock
//   reset     in  1        asynchronous active-high reset
//   shift     in  1        a data byte is being accepted this cycle
//   first     in  1        the byte on byte_in is b0 of a word
//   byte_in   in  8        stream byte
//   word      out 23       {b0[6:0], b1, byte_in}, valid while b2 is on byte_in
//   bad_lead  out 1        b0 has its top bit set (not a legal instruction)
// ---------------------------------------------------------------------------
module byte_packer
  import loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               shift,
  input  logic               first,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               bad_lead
);

  // Holds b0[6:0] and b1 once both have been shifted in; b0[7] falls off the top.
  localparam int SH_W = (BYTES_PER_WORD - 1) * 8 - 1;

  logic [SH_W-1:0] sh;

  // Shift every accepted data byte in from the bottom.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh <= '0;
    end else if (shift) begin
      sh <= {sh[SH_W-9:0], byte_in};
    end
  end

  assign word     = {sh, byte_in};
  assign bad_lead = first & byte_in[7];

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Receives a program as a byte stream (length byte, then 3 bytes per word,
// optionally a trailing XOR checksum) and writes each 23-bit word into the
// core's program memory from address 0 upward, then pulses start.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   -> a checksum byte (XOR of all data bytes) follows the data and
//                must match before start is issued.
//   undefined -> the last write goes straight to the start pulse.
//
// Ports:
//   clk         in  1       rising-edge clock
//   reset       in  1       asynchronous active-high reset
//   load_req    in  1       begin a load (honoured in IDLE and ERR)
//   byte_in     in  8       stream byte
//   byte_valid  in  1       byte_in is valid
//   byte_ready  out 1       loader accepts a byte this cycle
//   program_in  out 23      instruction word for program memory
//   address     out ADDR_W  program memory write address
//   write       out 1       program memory write strobe
//   start       out 1       one-cycle pulse after a successful load
//   busy        out 1       high except in IDLE and ERR
//   err         out 1       sticky error flag
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_req,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_valid,
  output logic                          byte_ready,
  output logic [loader_pkg::INSTR_W-1:0] program_in,
  output logic [ADDR_W-1:0]             address,
  output logic                          write,
  output logic                          start,
  output logic                          busy,
  output logic                          err
);

  import loader_pkg::*;

  localparam logic [8:0] MAX_LEN = 9'(MAX_WORDS);

  state_t state, next_state;

  logic               accept;
  logic               data_byte;
  logic               len_bad;
  logic [ADDR_W:0]    cnt;
  logic [ADDR_W:0]    cnt_next;
  logic [ADDR_W:0]    num_words;
  logic [INSTR_W-1:0] packed_word;
  logic               bad_lead;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  assign accept    = byte_valid & byte_ready;
  assign data_byte = (state == S_B0) || (state == S_B1) || (state == S_B2);
  assign len_bad   = (byte_in == 8'd0) || ({1'b0, byte_in} > MAX_LEN);
  assign cnt_next  = cnt + 1'b1;

  byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .shift    (accept & data_byte),
    .first    (state == S_B0),
    .byte_in  (byte_in),
    .word     (packed_word),
    .bad_lead (bad_lead)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake/strobe outputs. Every output is a pure function
  // of the state so reset clears them all immediately.
  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    write      = 1'b0;
    start      = 1'b0;
    busy       = 1'b1;
    err        = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (load_req) next_state = S_LEN;
      end
      S_LEN: begin
        byte_ready = 1'b1;
        if (byte_valid) next_state = len_bad ? S_ERR : S_B0;
      end
      S_B0: begin
        byte_ready = 1'b1;
        if (byte_valid) next_state = bad_lead ? S_ERR : S_B1;
      end
      S_B1: begin
        byte_ready = 1'b1;
        if (byte_valid) next_state = S_B2;
      end
      S_B2: begin
        byte_ready = 1'b1;
        if (byte_valid) next_state = S_WR;
      end
      S_WR: begin
        write = 1'b1;
        if (cnt_next < num_words) begin
          next_state = S_B0;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          next_state = S_CHK;
`else
          next_state = S_STRT;
`endif
        end
      end
      S_CHK: begin
`ifdef LOADER_CHECKSUM_EN
        byte_ready = 1'b1;
        if (byte_valid) next_state = (byte_in == csum) ? S_STRT : S_ERR;
`else
        next_state = S_IDLE;
`endif
      end
      S_STRT: begin
        start      = 1'b1;
        next_state = S_IDLE;
      end
      S_ERR: begin
        busy = 1'b0;
        err  = 1'b1;
        if (load_req) next_state = S_LEN;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Length/counter/output registers. program_in and address are captured on
  // the b2 transfer so they are stable throughout WR and hold afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      num_words  <= '0;
      program_in <= '0;
      address    <= '0;
    end else begin
      case (state)
        S_LEN: begin
          if (accept && !len_bad) begin
            num_words <= byte_in[ADDR_W:0];
            cnt       <= '0;
            address   <= '0;
          end
        end
        S_B2: begin
          if (accept) begin
            program_in <= packed_word;
            address    <= cnt[ADDR_W-1:0];
          end
        end
        S_WR: begin
          cnt <= cnt_next;
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of every data byte; the length byte only restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum <= '0;
    end else if (state == S_LEN && accept) begin
      csum <= '0;
    end else if (accept && data_byte) begin
      csum <= csum ^ byte_in;
    end
  end
`endif

endmodule
